// File: rtl/cpu_trace_buffer.sv
// CPU instruction trace buffer: captures {pc, inst, addr} whenever the PC changes
// while tracing is enabled, and exposes the oldest entry on a first-word-fall-through port.
module cpu_trace_buffer #(
   parameter int PTR_W = 4
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             trace_en,
   input  logic [31:0]      pc,
   input  logic [31:0]      inst,
   input  logic [31:0]      addr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_inst,
   output logic [31:0]      out_addr,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             overflow,
   output logic [15:0]      drop_cnt,
   input  logic             clr_ovf
);

   localparam int DEPTH = 2 ** PTR_W;
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

   logic [95:0]      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [31:0]      last_pc;
   logic             first_flag;

   logic cap_req;
   logic pop;
   logic push;
   logic drop;

   // Output handshake: an entry transfers in any cycle where out_valid && out_ready
   // are both high at the rising edge; out_* stay fixed until that transfer happens.
   assign out_valid = (count != '0);
   assign full      = (count == DEPTH_CNT);

   assign cap_req = trace_en && (first_flag || (pc != last_pc));
   assign pop     = out_valid && out_ready;
   assign push    = cap_req && (!full || pop);
   assign drop    = cap_req && full && !pop;

   assign out_pc   = mem[rd_ptr][95:64];
   assign out_inst = mem[rd_ptr][63:32];
   assign out_addr = mem[rd_ptr][31:0];

   // Storage has no reset; validity is tracked entirely by count.
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem[wr_ptr] <= {pc, inst, addr};
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + (PTR_W + 1)'(1);
         end else if (pop && !push) begin
            count <= count - (PTR_W + 1)'(1);
         end
      end
   end

   // Dedupe tracking: a disabled cycle re-arms capture of the next PC unconditionally.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         last_pc    <= '0;
         first_flag <= 1'b1;
      end else begin
         if (cap_req) begin
            last_pc <= pc;
         end
         if (!trace_en) begin
            first_flag <= 1'b1;
         end else if (cap_req) begin
            first_flag <= 1'b0;
         end
      end
   end

   // A drop wins over a coincident clear, leaving exactly one recorded drop.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clr_ovf) begin
            drop_cnt <= 16'd1;
         end else if (drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end else if (clr_ovf) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end

endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 SHALL have parameter PTR_W, default 4, FIFO pointer width; depth DEPTH = 2**PTR_W entries.
REQ-002 SHALL have port clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port trace_en  input  1  capture enable.
REQ-005 SHALL have port pc  input  32  CPU program counter (cpu_out_pc).
REQ-006 SHALL have port inst  input  32  CPU current instruction (cpu_out_inst).
REQ-007 SHALL have port addr  input  32  CPU ALU result / data address (cpu_out_alu).
REQ-008 SHALL have port out_valid  output  1  head entry available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-010 SHALL have port out_pc, out_inst, out_addr  output  32 each  head entry fields.
REQ-011 SHALL have port count  output  PTR_W+1  number of stored entries.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky: a capture was dropped.
REQ-014 SHALL have port drop_cnt  output  16  number of dropped captures, saturating.
REQ-015 SHALL have port clr_ovf  input  1  synchronous clear of overflow and drop_cnt.

Function
REQ-016 SHALL raise a capture request in a cycle when trace_en=1 and (first_flag=1 or pc != last_pc).
REQ-017 SHALL register pc into last_pc on every capture request, accepted or dropped.
REQ-018 SHALL set first_flag on reset and in any cycle trace_en=0; clear it on a capture request.
REQ-019 SHALL, on an accepted capture, write {pc, inst, addr} at the write pointer and advance it modulo DEPTH.
REQ-020 SHALL present the head entry first-word-fall-through; out_valid = (count != 0).
REQ-021 SHALL pop in a cycle when out_valid=1 and out_ready=1, advancing the read pointer modulo DEPTH.
REQ-022 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-023 SHALL assert out_valid the cycle after a capture into an empty buffer (1-cycle latency); no bypass.
REQ-024 SHALL, when full and no pop, drop the capture, set overflow, and increment drop_cnt saturating at 16'hFFFF.
REQ-025 SHALL, when full with simultaneous pop, accept the capture; count unchanged; no overflow.
REQ-026 SHALL, when empty, ignore out_ready; pointers and count unchanged.
REQ-027 SHALL, on simultaneous push and pop when not full, keep count unchanged.
REQ-028 SHALL, on clr_ovf=1 coincident with a drop, give the drop priority: overflow=1, drop_cnt=1.
REQ-029 SHALL treat pointer wrap-around from DEPTH-1 to 0 with no loss or duplication.
REQ-030 SHALL leave out_* don't-care when out_valid=0; bench does not check them.

Reset
REQ-031 SHALL, on reset, force asynchronously: count=0, full=0, out_valid=0, overflow=0, drop_cnt=0, both pointers=0, last_pc=0, first_flag=1.
REQ-032 SHALL, on reset asserted mid-operation, discard all stored entries; no pop is reported.
REQ-033 SHALL start capture on the first rising edge after reset deasserts when trace_en=1.
REQ-034 SHALL not reset storage array contents.

Verification
REQ-035 SHALL cover dedupe: trace_en=1, pc held at 0x00400000 for 3 cycles, then 0x00400004 -> exactly 2 entries, count=2.
REQ-036 SHALL cover basic order: 4 distinct pcs 0x0,0x4,0x8,0xC with out_ready=1 -> outputs in the same order, each with its matching inst/addr, out_valid one cycle after each capture.
REQ-037 SHALL cover overflow (PTR_W=4): 20 distinct pcs with out_ready=0 -> full=1, count=16, overflow=1, drop_cnt=4, head out_pc is the first pc.
REQ-038 SHALL cover full with pop: full buffer, one pop plus a new capture in the same cycle -> count stays 16, overflow stays 0.
REQ-039 SHALL cover clear priority: clr_ovf=1 in the same cycle as a drop -> overflow=1, drop_cnt=1; clr_ovf alone next cycle -> overflow=0, drop_cnt=0.
REQ-040 SHALL cover reset mid-stream: reset asserted with count=7 -> count=0, out_valid=0 immediately; no clock edge required.
